// File: rtl/trace_pkg.sv
// Shared constants, types and frame-byte helpers for the trace UART transmitter.
package trace_pkg;

  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
  localparam int unsigned FRAME_BYTES   = 15;
  localparam int unsigned BITS_PER_BYTE = 10;

  typedef enum logic [0:0] {StIdle, StSend} trace_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [5:0]  op;
  } snapshot_t;

  function automatic logic [7:0] fold_word(logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  // Byte idx of the frame built from a latched snapshot; byte 14 is the XOR of bytes 1..13.
  function automatic logic [7:0] frame_byte(snapshot_t s, logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:  b = SYNC_BYTE;
      4'd1:  b = s.pc[31:24];
      4'd2:  b = s.pc[23:16];
      4'd3:  b = s.pc[15:8];
      4'd4:  b = s.pc[7:0];
      4'd5:  b = s.alu_result[31:24];
      4'd6:  b = s.alu_result[23:16];
      4'd7:  b = s.alu_result[15:8];
      4'd8:  b = s.alu_result[7:0];
      4'd9:  b = s.write_data[31:24];
      4'd10: b = s.write_data[23:16];
      4'd11: b = s.write_data[15:8];
      4'd12: b = s.write_data[7:0];
      4'd13: b = {2'b00, s.op};
      4'd14: b = fold_word(s.pc) ^ fold_word(s.alu_result) ^ fold_word(s.write_data) ^
                 {2'b00, s.op};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready pulses in the last cycle of the stop bit so the next
// byte can be loaded on that same edge with no idle gap.
module uart_tx_byte
  import trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic            active_q, active_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            baud_end, last_bit;

  assign baud_end = (baud_q == CntW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_q == 4'(BITS_PER_BYTE - 1));
  assign ready    = active_q & baud_end & last_bit;
  assign tx       = tx_q;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (active_q) begin
      if (baud_end) begin
        baud_d = '0;
        if (last_bit) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[9:1]};
          tx_d    = shift_q[1];
        end
      end else begin
        baud_d = baud_q + CntW'(1);
      end
    end
    // Load overrides the stop-bit completion so back-to-back bytes have no gap.
    if (start && (!active_q || ready)) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = 4'd0;
      shift_d  = {1'b1, data, 1'b0};
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/trace_uart_tx.sv
// Captures one CPU retire snapshot and streams it as a 15-byte 8N1 frame;
// snapshots arriving mid-frame are dropped and counted.
module trace_uart_tx
  import trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        trace_valid,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [5:0]  op,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt
);

  trace_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  snapshot_t    snap_q, snap_d;
  logic         done_q, done_d;
  logic [7:0]   ovr_q, ovr_d;
  logic         ser_start, ser_ready;
  logic [7:0]   ser_data;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .Rst  (Rst),
    .start(ser_start),
    .data (ser_data),
    .tx   (tx),
    .ready(ser_ready)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q;
    ser_start = 1'b0;
    ser_data  = SYNC_BYTE;
    unique case (state_q)
      StIdle: begin
        if (trace_valid) begin
          snap_d    = '{pc: pc, alu_result: alu_result, write_data: write_data, op: op};
          state_d   = StSend;
          idx_d     = 4'd0;
          ser_start = 1'b1;
          ser_data  = SYNC_BYTE;
        end
      end
      StSend: begin
        if (trace_valid && (ovr_q != 8'hFF)) begin
          ovr_d = ovr_q + 8'd1;
        end
        if (ser_ready) begin
          if (idx_q == 4'(FRAME_BYTES - 1)) begin
            state_d = StIdle;
            idx_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + 4'd1;
            ser_start = 1'b1;
            ser_data  = frame_byte(snap_q, idx_q + 4'd1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy        = (state_q == StSend);
  assign frame_done  = done_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench for trace_uart_tx with CLKS_PER_BIT=4 (600-cycle frames).
module tb_trace_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 150 * CPB;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [5:0]  op;
    logic [7:0]  csum;
  } vec_t;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        trace_valid = 1'b0;
  logic [31:0] pc = '0, alu_result = '0, write_data = '0;
  logic [5:0]  op = '0;
  logic        tx, busy, frame_done;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;
  logic cap [1:FRAME];
  vec_t vecs [5];

  trace_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .Rst        (Rst),
    .trace_valid(trace_valid),
    .pc         (pc),
    .alu_result (alu_result),
    .write_data (write_data),
    .op         (op),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; the pulse is sampled at the next posedge (accept edge).
  // Returns at the negedge of cycle 1 of the frame.
  task automatic launch(input vec_t v);
    trace_valid = 1'b1;
    pc = v.pc;
    alu_result = v.alu;
    write_data = v.wd;
    op = v.op;
    @(negedge clk);
    trace_valid = 1'b0;
  endtask

  // Samples cycles 1..600, optionally pulsing trace_valid in the first 'pulses' cycles,
  // then checks the frame_done cycle and every bit cell of all 15 bytes.
  task automatic capture(input vec_t v, input int pulses, input string tag);
    logic [7:0]  fb [15];
    logic [39:0] act, exp;
    logic        val;
    logic        busy_ok, fd_ok;
    busy_ok = 1'b1;
    fd_ok = 1'b1;
    fb[0] = 8'hA5;
    fb[1] = v.pc[31:24];  fb[2] = v.pc[23:16];  fb[3] = v.pc[15:8];  fb[4] = v.pc[7:0];
    fb[5] = v.alu[31:24]; fb[6] = v.alu[23:16]; fb[7] = v.alu[15:8]; fb[8] = v.alu[7:0];
    fb[9] = v.wd[31:24];  fb[10] = v.wd[23:16]; fb[11] = v.wd[15:8]; fb[12] = v.wd[7:0];
    fb[13] = {2'b00, v.op};
    fb[14] = v.csum;
    for (int k = 1; k <= FRAME; k++) begin
      cap[k] = tx;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (frame_done !== 1'b0) fd_ok = 1'b0;
      if (k <= pulses) begin
        trace_valid = 1'b1;
        pc = ~v.pc;
        alu_result = ~v.alu;
        write_data = ~v.wd;
        op = ~v.op;
      end else begin
        trace_valid = 1'b0;
      end
      @(negedge clk);
    end
    trace_valid = 1'b0;
    check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, "_done_quiet"}, 64'(fd_ok), 64'd1);
    check({tag, "_done_pulse"}, 64'({frame_done, busy, tx}), 64'(3'b101));
    for (int b = 0; b < 15; b++) begin
      for (int i = 0; i < 10; i++) begin
        val = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : fb[b][i-1];
        for (int c = 0; c < CPB; c++) begin
          exp[i*CPB+c] = val;
          act[i*CPB+c] = cap[b*10*CPB + i*CPB + c + 1];
        end
      end
      check($sformatf("%s_byte%0d", tag, b), 64'(act), 64'(exp));
    end
  endtask

  initial begin
    //             pc            alu           wd            op     csum
    vecs[0] = '{32'h00000004, 32'h0000000A, 32'h12345678, 6'h23, 8'h25};
    vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 6'h00, 8'h00};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h3F, 8'h3F};
    vecs[3] = '{32'hDEADBEEF, 32'h00000001, 32'h80000000, 6'h2B, 8'h88};
    vecs[4] = '{32'h01020304, 32'h10203040, 32'hA5A5A5A5, 6'h15, 8'h51};

    // Reset then idle: line high, nothing in flight.
    Rst = 1'b1;
    trace_valid = 1'b1;
    repeat (5) @(negedge clk);
    Rst = 1'b0;
    trace_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("idle_%0d", k), 64'({tx, busy, frame_done, overrun_cnt}),
            64'({1'b1, 1'b0, 1'b0, 8'd0}));
      @(negedge clk);
    end

    // Table frames, chained back-to-back: each launch lands in the prior frame_done cycle.
    for (int n = 0; n < 5; n++) begin
      launch(vecs[n]);
      capture(vecs[n], 0, $sformatf("vec%0d", n));
      check($sformatf("vec%0d_ovr", n), 64'(overrun_cnt), 64'd0);
    end
    @(negedge clk);
    check("done_one_cycle", 64'(frame_done), 64'd0);

    // Small overrun: three drops, snapshot untouched.
    launch(vecs[0]);
    capture(vecs[0], 3, "ovr3");
    check("ovr3_cnt", 64'(overrun_cnt), 64'd3);

    // Heavy overrun saturates at 255.
    launch(vecs[3]);
    capture(vecs[3], 300, "ovr300");
    check("ovr300_cnt", 64'(overrun_cnt), 64'd255);
    @(negedge clk);
    check("ovr300_done_clear", 64'(frame_done), 64'd0);

    // Reset during byte 5's data bits (cycle 210), with trace_valid held high under reset.
    launch(vecs[3]);
    repeat (209) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    Rst = 1'b1;
    trace_valid = 1'b1;
    @(negedge clk);
    check("rst_mid_state", 64'({tx, busy, frame_done, overrun_cnt}),
          64'({1'b1, 1'b0, 1'b0, 8'd0}));
    @(negedge clk);
    Rst = 1'b0;
    trace_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("post_rst_%0d", k), 64'({tx, busy}), 64'({1'b1, 1'b0}));
      @(negedge clk);
    end
    launch(vecs[4]);
    capture(vecs[4], 0, "after_rst");
    check("after_rst_ovr", 64'(overrun_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
